// File: rtl/sub_arbiter_if.sv
// Bus bundle between the two requesters and the shared subtractor.
// The master modport is the requester side; the slave modport is the arbiter.
interface sub_arbiter_if;
    logic       req0;
    logic       req1;
    logic [7:0] a0;
    logic [7:0] b0;
    logic [7:0] a1;
    logic [7:0] b1;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [7:0] result;
    logic       neg;
    logic       busy;

    modport master (
        output req0, req1, a0, b0, a1, b1,
        input  gnt0, gnt1, done0, done1, result, neg, busy
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1,
        output gnt0, gnt1, done0, done1, result, neg, busy
    );
endinterface

// File: rtl/sub_arbiter.sv
// Two-requester round-robin arbiter in front of one shared 8-bit subtractor.
// Each operation returns |a-b| plus a borrow flag after a fixed four-cycle
// IDLE -> SUB -> FIX -> DONE walk.
// Build option: define SUB_ARB_CLAMP_EN for a saturating subtract (a<b gives
// result 0, borrow still reported on neg). Undefined gives the magnitude.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no operation; arbitrate pending requests, latch operands
// SUB   | RA <= RA - RB (mod 256), capture borrow
// FIX   | turn a negative difference into its magnitude (or leave it)
// DONE  | done pulse to the owner; result/neg/prio update on exit edge
module sub_arbiter (
    input  logic          clk,
    input  logic          rst,
    sub_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic [7:0] r_ra;
    logic [7:0] r_rb;
    logic       r_borrow;
    logic       r_owner;     // 0: requester 0 holds the subtractor, 1: requester 1
    logic       r_prio;      // requester favoured when both ask at once
    logic       r_gnt0;
    logic       r_gnt1;
    logic [7:0] r_result;
    logic       r_neg;

    logic       w_any_req;
    logic       w_pick1;
    logic [7:0] w_a_sel;
    logic [7:0] w_b_sel;
    logic [7:0] w_final;

    // Round-robin pick: a lone request wins, a tie goes to the prio pointer.
    always_comb begin
        w_any_req = bus.req0 | bus.req1;
        w_pick1   = bus.req1 & (~bus.req0 | r_prio);
        w_a_sel   = w_pick1 ? bus.a1 : bus.a0;
        w_b_sel   = w_pick1 ? bus.b1 : bus.b0;
    end

    // Value committed to result on the DONE exit edge.
    always_comb begin
`ifdef SUB_ARB_CLAMP_EN
        w_final = r_borrow ? 8'd0 : r_ra;
`else
        w_final = r_ra;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; the walk after a grant is unconditional, so a request
    // dropping mid-operation still runs to DONE.
    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE:  w_next_state = w_any_req ? S_SUB : S_IDLE;
            S_SUB:   w_next_state = S_FIX;
            S_FIX:   w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath, grants, pointer and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ra     <= 8'd0;
            r_rb     <= 8'd0;
            r_borrow <= 1'b0;
            r_owner  <= 1'b0;
            r_prio   <= 1'b0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_result <= 8'd0;
            r_neg    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_pick1;
                        r_ra    <= w_a_sel;
                        r_rb    <= w_b_sel;
                        r_gnt0  <= ~w_pick1;
                        r_gnt1  <= w_pick1;
                    end
                end
                S_SUB: begin
                    r_ra     <= r_ra - r_rb;
                    r_borrow <= (r_ra < r_rb);
                end
                S_FIX: begin
`ifndef SUB_ARB_CLAMP_EN
                    if (r_borrow) begin
                        r_ra <= (~r_ra) + 8'd1;
                    end
`endif
                end
                S_DONE: begin
                    r_result <= w_final;
                    r_neg    <= r_borrow;
                    r_gnt0   <= 1'b0;
                    r_gnt1   <= 1'b0;
                    r_prio   <= ~r_owner;
                end
                default: begin
                    r_gnt0 <= 1'b0;
                    r_gnt1 <= 1'b0;
                end
            endcase
        end
    end

    // Output decode: done pulses and busy come straight from the state.
    always_comb begin
        bus.done0  = (r_state == S_DONE) & ~r_owner;
        bus.done1  = (r_state == S_DONE) &  r_owner;
        bus.busy   = (r_state != S_IDLE);
        bus.gnt0   = r_gnt0;
        bus.gnt1   = r_gnt1;
        bus.result = r_result;
        bus.neg    = r_neg;
    end

endmodule

// File: tb/tb_sub_arbiter.sv
// Directed bench for sub_arbiter with a scoreboard of expected results.
module tb_sub_arbiter;

    typedef struct {
        bit         owner;
        logic [7:0] res;
        logic       neg;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    exp_t sbq[$];

    sub_arbiter_if bus_if ();

    sub_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input bit who, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.owner = who;
        e.neg   = (a < b);
        e.res   = e.neg ? 8'(b - a) : 8'(a - b);
`ifdef SUB_ARB_CLAMP_EN
        if (e.neg) e.res = 8'd0;
`endif
        return e;
    endfunction

    // Grants must be exclusive and busy must track ownership.
    always @(negedge clk) begin
        if (!rst) begin
            chk("gnt_excl", {31'd0, bus_if.gnt0 & bus_if.gnt1}, 32'd0);
            chk("busy_vs_gnt", {31'd0, bus_if.busy}, {31'd0, bus_if.gnt0 | bus_if.gnt1});
        end
    end

    task automatic check_result(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_res"}, {24'd0, bus_if.result}, {24'd0, e.res});
            chk({tag, "_neg"}, {31'd0, bus_if.neg}, {31'd0, e.neg});
        end
    endtask

    task automatic set_ops(input bit who, input logic [7:0] a, input logic [7:0] b);
        if (who) begin
            bus_if.a1 = a; bus_if.b1 = b;
        end else begin
            bus_if.a0 = a; bus_if.b0 = b;
        end
    endtask

    task automatic do_op(input string tag, input bit who, input logic [7:0] a,
                         input logic [7:0] b, input bit disturb, input bit drop_early);
        set_ops(who, a, b);
        if (who) bus_if.req1 = 1'b1; else bus_if.req0 = 1'b1;
        sbq.push_back(model(who, a, b));
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk({tag, "_gnt"}, {31'd0, who ? bus_if.gnt1 : bus_if.gnt0}, 32'd1);
            chk({tag, "_done"}, {31'd0, who ? bus_if.done1 : bus_if.done0}, {31'd0, c == 3});
            chk({tag, "_done_other"}, {31'd0, who ? bus_if.done0 : bus_if.done1}, 32'd0);
            if (c == 1 && disturb) set_ops(who, ~a, a ^ b ^ 8'h5A);
            if (c == 1 && drop_early) begin
                if (who) bus_if.req1 = 1'b0; else bus_if.req0 = 1'b0;
            end
        end
        bus_if.req0 = 1'b0;
        bus_if.req1 = 1'b0;
        @(negedge clk);
        check_result(tag);
        chk({tag, "_idle_busy"}, {31'd0, bus_if.busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt0"},   {31'd0, bus_if.gnt0},  32'd0);
        chk({tag, "_gnt1"},   {31'd0, bus_if.gnt1},  32'd0);
        chk({tag, "_done0"},  {31'd0, bus_if.done0}, 32'd0);
        chk({tag, "_done1"},  {31'd0, bus_if.done1}, 32'd0);
        chk({tag, "_result"}, {24'd0, bus_if.result}, 32'd0);
        chk({tag, "_neg"},    {31'd0, bus_if.neg},   32'd0);
        chk({tag, "_busy"},   {31'd0, bus_if.busy},  32'd0);
    endtask

    initial begin
        int  cycles;
        bit  found;
        bit  who;
        exp_t e;

        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus_if.req0 = 1'b0; bus_if.req1 = 1'b0;
        bus_if.a0 = 8'd0; bus_if.b0 = 8'd0; bus_if.a1 = 8'd0; bus_if.b1 = 8'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        do_op("single0",   1'b0, 8'd200, 8'd55,  1'b0, 1'b0);
        do_op("borrow1",   1'b1, 8'd10,  8'd30,  1'b0, 1'b0);
        do_op("equal",     1'b0, 8'd77,  8'd77,  1'b0, 1'b0);
        do_op("zero_255",  1'b1, 8'd0,   8'd255, 1'b0, 1'b0);
        do_op("disturb",   1'b0, 8'd90,  8'd33,  1'b1, 1'b0);
        do_op("drop_mid",  1'b1, 8'd3,   8'd250, 1'b0, 1'b1);

        // Contention: both requests held from reset release.
        rst = 1'b1;
        @(negedge clk);
        bus_if.a0 = 8'd50; bus_if.b0 = 8'd20;
        bus_if.a1 = 8'd5;  bus_if.b1 = 8'd9;
        bus_if.req0 = 1'b1; bus_if.req1 = 1'b1;
        sbq.push_back(model(1'b0, 8'd50, 8'd20));
        sbq.push_back(model(1'b1, 8'd5,  8'd9));
        sbq.push_back(model(1'b0, 8'd50, 8'd20));
        sbq.push_back(model(1'b1, 8'd5,  8'd9));
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            cycles = 0;
            found  = 1'b0;
            who    = 1'b0;
            while (!found && cycles < 12) begin
                @(negedge clk);
                cycles++;
                if (bus_if.done0 | bus_if.done1) begin
                    found = 1'b1;
                    who   = bus_if.done1;
                end
            end
            chk("rr_done_seen", {31'd0, found}, 32'd1);
            chk("rr_spacing", cycles, 32'd3);
            if (sbq.size() > 0) begin
                e = sbq[0];
                chk("rr_order", {31'd0, who}, {31'd0, e.owner});
            end
            if (n == 3) begin
                bus_if.req0 = 1'b0;
                bus_if.req1 = 1'b0;
            end
            @(negedge clk);
            check_result("rr");
        end

        // Reset during FIX aborts the operation silently.
        bus_if.a0 = 8'd100; bus_if.b0 = 8'd1;
        bus_if.req0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_gnt_fix", {31'd0, bus_if.gnt0}, 32'd1);
        rst = 1'b1;
        bus_if.req0 = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, bus_if.done0 | bus_if.done1}, 32'd0);
            chk("abort_idle", {31'd0, bus_if.busy}, 32'd0);
        end
        do_op("after_abort", 1'b1, 8'd33, 8'd200, 1'b0, 1'b0);

        chk("sb_drained", sbq.size(), 32'd0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
